// File: rtl/sysid_info_regs.sv
// System-ID / build-info / uptime register block on an Avalon-MM slave.
// Latency: READ_LATENCY cycles from accepted read to readdatavalid; writes take effect next cycle.
// Backpressure: none (no waitrequest); every read and write is accepted in the cycle it is asserted.
//
// Ports: clock, reset_n (async active-low); address[2:0], read, write, writedata[31:0],
//        byteenable[3:0] in; readdata[31:0], readdatavalid out.
// Optional: define SYSID_UPTIME_EN to build the prescaler, 64-bit uptime counter and high-word
//           shadow. Without it, words 2/3 read 0, CTRL writes are ignored and INFO[15:0] reads 0.
module sysid_info_regs #(
    parameter logic [31:0] ID           = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter logic [15:0] VERSION      = 16'h0002,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("sysid_info_regs: PRESCALE must be 1..65535");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("sysid_info_regs: READ_LATENCY must be 1..4");
    end

    logic [31:0] scratch;
    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic [15:0] info_lo;
    logic [31:0] rdata_mux;

    // Scratch register, byte-lane writable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_INIT;
        end else if (write && (address == 3'd4)) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

`ifdef SYSID_UPTIME_EN
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic [63:0] uptime;
    logic [31:0] shadow;
    logic        clr;
    logic        tick;
    logic        lo_rd;

    assign clr   = write && (address == 3'd7) && writedata[0];
    assign tick  = (presc == PRESCALE_MAX);
    assign lo_rd = read && (address == 3'd2);

    // Clear has priority over the tick, so a clear in the wrap cycle leaves 0, not 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            uptime <= '0;
        end else if (clr) begin
            presc  <= '0;
            uptime <= '0;
        end else if (tick) begin
            presc  <= '0;
            uptime <= uptime + 64'd1;
        end else begin
            presc  <= presc + 16'd1;
        end
    end

    // A low-word read latches the high word of the same (pre-increment) sample,
    // giving software a tear-free 64-bit read. Clear wins over the load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (clr) begin
            shadow <= '0;
        end else if (lo_rd) begin
            shadow <= uptime[63:32];
        end
    end

    assign up_lo   = uptime[31:0];
    assign up_hi   = shadow;
    assign info_lo = 16'(PRESCALE);
`else
    assign up_lo   = '0;
    assign up_hi   = '0;
    assign info_lo = '0;
`endif

    // Read data is formed from current (pre-write) state in the accept cycle.
    always_comb begin
        rdata_mux = '0;
        case (address)
            3'd0:    rdata_mux = ID;
            3'd1:    rdata_mux = TIMESTAMP;
            3'd2:    rdata_mux = up_lo;
            3'd3:    rdata_mux = up_hi;
            3'd4:    rdata_mux = scratch;
            3'd5:    rdata_mux = {VERSION, info_lo};
            default: rdata_mux = '0;
        endcase
    end

    // Valid and data shift together; reset flushes anything in flight.
    logic [READ_LATENCY-1:0]       pipe_vld;
    logic [READ_LATENCY-1:0][31:0] pipe_dat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            pipe_dat <= '0;
        end else begin
            pipe_vld[0] <= read;
            pipe_dat[0] <= read ? rdata_mux : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign readdata      = pipe_dat[READ_LATENCY-1];
    assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
// Bench for sysid_info_regs: two instances (latency 2 / prescale 1000 and latency 3 / prescale 4)
// share one request bus; each response stream is collected and checked for data and latency.
// Bus is driven on falling edges, outputs are sampled on falling edges.
module tb_sysid_info_regs;

`ifdef SYSID_UPTIME_EN
    localparam bit UP_EN = 1'b1;
`else
    localparam bit UP_EN = 1'b0;
`endif

    localparam logic [31:0] ID_A   = 32'h5A8F_1C33;
    localparam logic [31:0] TS_A   = 32'h1234_5678;
    localparam logic [31:0] ID_B   = 32'h0BAD_F00D;
    localparam logic [31:0] TS_B   = 32'h2024_0101;
    localparam logic [31:0] INIT_B = 32'hA5A5_0F0F;
    localparam logic [31:0] INFO_A = UP_EN ? 32'h0002_03E8 : 32'h0002_0000;
    localparam logic [31:0] INFO_B = UP_EN ? 32'h0103_0004 : 32'h0103_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] rd_a, rd_b;
    logic        rv_a, rv_b;

    always #5 clock = ~clock;

    sysid_info_regs #(
        .ID(ID_A), .TIMESTAMP(TS_A), .VERSION(16'h0002), .PRESCALE(1000),
        .READ_LATENCY(2), .SCRATCH_INIT(32'h0000_0000)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd_a), .readdatavalid(rv_a)
    );

    sysid_info_regs #(
        .ID(ID_B), .TIMESTAMP(TS_B), .VERSION(16'h0103), .PRESCALE(4),
        .READ_LATENCY(3), .SCRATCH_INIT(INIT_B)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd_b), .readdatavalid(rv_b)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } rvec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;
    int iq_a[$];
    int iq_b[$];
    logic [31:0] dq_a[$];
    logic [31:0] dq_b[$];
    logic [31:0] ea_q[$];
    logic [31:0] eb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic rvec_t mk(input logic [2:0] a, input logic [31:0] ea, input logic [31:0] eb);
        rvec_t v;
        v.addr  = a;
        v.exp_a = ea;
        v.exp_b = eb;
        return v;
    endfunction

    // Record issue cycle of every accepted read; reset drops in-flight reads.
    always @(posedge clock) begin
        if (!reset_n) begin
            iq_a.delete();
            iq_b.delete();
        end else if (read) begin
            iq_a.push_back(cyc);
            iq_b.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Collect responses and check each arrives exactly READ_LATENCY cycles after its read.
    always @(negedge clock) begin
        if (rv_a) begin
            vcnt_a++;
            dq_a.push_back(rd_a);
            if (iq_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL lat_a_orphan: got valid with data %h, expected no valid", rd_a);
            end else begin
                chk("lat_a", 32'(cyc - iq_a.pop_front()), 32'd2);
            end
        end
        if (rv_b) begin
            vcnt_b++;
            dq_b.push_back(rd_b);
            if (iq_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL lat_b_orphan: got valid with data %h, expected no valid", rd_b);
            end else begin
                chk("lat_b", 32'(cyc - iq_b.pop_front()), 32'd3);
            end
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        byteenable = be;
        @(negedge clock);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic expect2(input logic [31:0] a, input logic [31:0] b);
        ea_q.push_back(a);
        eb_q.push_back(b);
    endtask

    // Drain the pipes, then compare collected responses with the expected queues.
    task automatic check_q(input string tag);
        repeat (6) @(negedge clock);
        chk({tag, "_cnt_a"}, 32'(dq_a.size()), 32'(ea_q.size()));
        chk({tag, "_cnt_b"}, 32'(dq_b.size()), 32'(eb_q.size()));
        foreach (ea_q[i]) begin
            if (i < dq_a.size()) chk($sformatf("%s_a%0d", tag, i), dq_a[i], ea_q[i]);
        end
        foreach (eb_q[i]) begin
            if (i < dq_b.size()) chk($sformatf("%s_b%0d", tag, i), dq_b[i], eb_q[i]);
        end
        dq_a.delete(); dq_b.delete();
        ea_q.delete(); eb_q.delete();
    endtask

    task automatic run_table(input rvec_t t[$], input string tag);
        foreach (t[i]) begin
            bus(1'b1, 1'b0, t[i].addr, 32'h0, 4'h0);
            expect2(t[i].exp_a, t[i].exp_b);
        end
        idle();
        check_q(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_a"}, rd_a, 32'h0);
        chk({tag, "_rv_a"}, 32'(rv_a), 32'h0);
        chk({tag, "_rd_b"}, rd_b, 32'h0);
        chk({tag, "_rv_b"}, 32'(rv_b), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : main
        rvec_t tbl1[$];
        rvec_t tbl2[$];
        int rel;
        int v0a, v0b;

        // Back-to-back reads right after reset (words 6, 7 read 0; shadow starts at 0).
        tbl1.push_back(mk(3'd0, ID_A,   ID_B));
        tbl1.push_back(mk(3'd1, TS_A,   TS_B));
        tbl1.push_back(mk(3'd5, INFO_A, INFO_B));
        tbl1.push_back(mk(3'd6, 32'h0,  32'h0));
        tbl1.push_back(mk(3'd7, 32'h0,  32'h0));
        tbl1.push_back(mk(3'd3, 32'h0,  32'h0));
        tbl1.push_back(mk(3'd4, 32'h0,  INIT_B));
        // After a mid-flight reset: scratch back to init, shadow 0, info unchanged.
        tbl2.push_back(mk(3'd4, 32'h0,  INIT_B));
        tbl2.push_back(mk(3'd3, 32'h0,  32'h0));
        tbl2.push_back(mk(3'd5, INFO_A, INFO_B));
        tbl2.push_back(mk(3'd0, ID_A,   ID_B));

        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        rel = cyc;

        run_table(tbl1, "basic");

        // 40 clock edges after reset release with PRESCALE=4 -> uptime 10.
        while (cyc < rel + 40) @(negedge clock);
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        idle();
        expect2(32'h0, UP_EN ? 32'd10 : 32'd0);
        expect2(32'h0, 32'h0);
        check_q("uptime40");

        // Scratch: full write, partial lane write with same-cycle read, RO/reserved writes.
        bus(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, 4'b1111);
        bus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        bus(1'b1, 1'b1, 3'd4, 32'h00AA_0000, 4'b0100);
        bus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        bus(1'b0, 1'b1, 3'd4, 32'h1111_1111, 4'b0000);
        bus(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'b1111);
        bus(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'b1111);
        bus(1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 4'b1111);
        bus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd6, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        idle();
        expect2(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        expect2(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        expect2(32'hDEAA_BEEF, 32'hDEAA_BEEF);
        expect2(32'hDEAA_BEEF, 32'hDEAA_BEEF);
        expect2(ID_A, ID_B);
        expect2(32'h0, 32'h0);
        expect2(INFO_A, INFO_B);
        check_q("scratch");

`ifdef SYSID_UPTIME_EN
        // Low-word carry in the tick cycle: capture is pre-increment, shadow gets old high word.
        force dut_b.uptime = 64'h0000_0000_FFFF_FFFF;
        force dut_b.presc  = 16'd3;
        #1;
        release dut_b.uptime;
        release dut_b.presc;
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        idle();
        expect2(32'h0, 32'hFFFF_FFFF);
        expect2(32'h0, 32'h0);
        expect2(32'h0, 32'h0);
        expect2(32'h0, 32'h1);
        check_q("wrap");

        // Clear in the prescaler-wrap cycle: counter, prescaler and shadow all restart at 0,
        // so the next tick lands exactly 4 edges after the clear.
        force dut_b.uptime = 64'd5;
        force dut_b.presc  = 16'd3;
        #1;
        release dut_b.uptime;
        release dut_b.presc;
        bus(1'b0, 1'b1, 3'd7, 32'h0000_0001, 4'b1111);
        bus(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        idle();
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        idle();
        expect2(32'h0, 32'h0);
        expect2(32'h0, 32'h0);
        expect2(32'h0, 32'h0);
        expect2(32'h0, 32'h1);
        check_q("clear");
`endif

        // Reset one cycle after a read: the in-flight response must never appear.
        v0a = vcnt_a;
        v0b = vcnt_b;
        bus(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        read    = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("midrst");
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        chk("midrst_nvld_a", 32'(vcnt_a - v0a), 32'd0);
        chk("midrst_nvld_b", 32'(vcnt_b - v0b), 32'd0);
        dq_a.delete();
        dq_b.delete();

        run_table(tbl2, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
